distance_filter: RTL and testbench
==================================

// Module: distance_filter
// PURPOSE
//  Cleans raw HC-SR04 range readings before the display and motor_controller use them.
//  Sits between hc_sr04_interface (distance_cm, measurement_ready) and its consumers.
//  - Rejects out-of-range samples.
//  - Takes the median of the last 3 valid samples.
//  - Holds the last good value between updates.
//  - Flags a stale sensor after repeated bad readings.
// PARAMETERS
//  WIDTH        16   distance bus width (cm)
//  MIN_CM       2    smallest accepted distance, inclusive
//  MAX_CM       400  largest accepted distance, inclusive
//  DEFAULT_CM   25   distance_out value after reset
//  STALE_LIMIT  8    consecutive invalid samples before stale asserts (1..255)
// PORTS
//  clk           in   1      system clock; all inputs synchronous to it
//  reset         in   1      synchronous, active-high
//  distance_in   in   WIDTH  raw distance from sensor interface
//  meas_ready    in   1      sample-ready, level or pulse; rising edge = new sample
//  distance_out  out  WIDTH  filtered distance, held between updates
//  out_valid     out  1      1-cycle strobe when distance_out is written
//  stale         out  1      STALE_LIMIT consecutive invalid samples seen
//  reject_count  out  8      total rejected samples, saturates at 255
// BEHAVIOUR
//  Reset values (clk edge with reset=1):
//   - distance_out=DEFAULT_CM; out_valid=0; stale=0; reject_count=0
//   - window cleared; fill=0; invalid run counter=0
//   - edge-detect register=1, so meas_ready held high through reset is NOT a sample
//  Sample detect: cycle N where meas_ready=1 and it was 0 at N-1.
//   - One sample per rising edge, however long the level is held.
//   - distance_in is captured at cycle N.
//  Validity: valid iff MIN_CM <= d <= MAX_CM, unsigned compare.
//  Valid sample, window update at N+1:
//   - Shift into 3-entry window w0 (newest), w1, w2; fill saturates at 3.
//   - Clear invalid run counter and stale.
//  Invalid sample, at N+1:
//   - Window unchanged; reject_count+1 (saturating).
//   - Run counter+1, saturating at STALE_LIMIT.
//   - When run counter reaches STALE_LIMIT: stale=1 and fill=0.
//     Window contents are kept but ignored; the next valid sample passes straight through.
//  Fill state machine (fill states):
//   - EMPTY -(valid)-> ONE -(valid)-> TWO -(valid)-> FULL; FULL -(valid)-> FULL
//   - Any state -(stale trip)-> EMPTY
//  Output stage at N+2 (valid samples only):
//   - EMPTY/ONE/TWO: distance_out = w0 (newest sample).
//   - FULL: distance_out = median(w0,w1,w2); ties resolve to the repeated value.
//   - out_valid=1 for exactly that cycle.
//  Invalid samples never write distance_out and never pulse out_valid.
//  Latency: rising edge at N -> distance_out/out_valid at N+2.
//  Throughput: one sample per 2 cycles.
//   - An edge arriving while the previous sample is in flight is processed in order.
//   - Edges cannot be closer than 2 cycles.
//  Reset wins over a sample in flight: the sample is discarded and no out_valid pulse occurs.
//  Median is built from pure compare/select logic, WIDTH bits, with no arithmetic overflow.
// TESTING
//  T1 reset, meas_ready held 1 -> distance_out=25, out_valid=0; no sample until meas_ready drops and rises
//  T2 samples 100,200,150 -> out 100,200 (window filling), then 150 (median); each out_valid 2 cycles after its edge
//  T3 window 100,102,101, then spike 390 -> out 102; then 0 and 500 -> out stays 102, reject_count=2, no out_valid
//  T4 8 consecutive samples of 0 -> stale=1 after 8th; then 50 -> out 50, stale=0 at same update; then 60 -> out 60
//  T5 meas_ready high for 20 cycles with distance_in changing -> exactly one sample, value at edge cycle
//  T6 reset asserted 1 cycle after a valid edge -> no out_valid; outputs return to reset values; reject_count saturates at 255 (stress)

Source files
------------

// File: rtl/distance_filter.sv
// distance_filter: range-gates raw sonar samples, median-of-3 filters valid ones,
// holds the last good distance and flags a stale sensor after a run of bad samples.
module distance_filter #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned MIN_CM      = 2,
   parameter int unsigned MAX_CM      = 400,
   parameter int unsigned DEFAULT_CM  = 25,
   parameter int unsigned STALE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] distance_in,
   input  logic             meas_ready,
   output logic [WIDTH-1:0] distance_out,
   output logic             out_valid,
   output logic             stale,
   output logic [7:0]       reject_count
);
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_CM);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CM);
   localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT_CM);
   localparam logic [7:0]       RUN_LIM = 8'(STALE_LIMIT);

   typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_t;

   fill_t            fill_q, fill_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
   logic [7:0]       run_q, run_d, rej_q, rej_d, run_inc;
   logic             stale_q, stale_d, pend_q, pend_d;
   logic [WIDTH-1:0] out_q, out_d, med;
   logic             out_valid_q, out_valid_d;
   logic             sample, in_ok, good, bad, trip, full;

   assign sample  = meas_ready & ~ready_q;
   assign in_ok   = (distance_in >= MIN_V) && (distance_in <= MAX_V);
   assign good    = sample & in_ok;
   assign bad     = sample & ~in_ok;
   assign run_inc = (run_q == RUN_LIM) ? run_q : run_q + 8'd1;
   assign trip    = bad && (run_inc == RUN_LIM);

   // Stage 1: window shift, invalid-run tracking, reject counting.
   always_comb begin
      ready_d = meas_ready;
      w0_d    = good ? distance_in : w0_q;
      w1_d    = good ? w0_q : w1_q;
      w2_d    = good ? w1_q : w2_q;
      run_d   = good ? 8'd0 : (bad ? run_inc : run_q);
      stale_d = good ? 1'b0 : (stale_q | trip);
      rej_d   = (bad && rej_q != 8'hff) ? rej_q + 8'd1 : rej_q;
      pend_d  = good;
   end

   // Fill FSM: state register.
   always_ff @(posedge clk) begin
      if (reset) fill_q <= EMPTY;
      else       fill_q <= fill_d;
   end

   // Fill FSM: next state; a stale trip overrides everything.
   always_comb begin
      fill_d = fill_q;
      if (trip)
         fill_d = EMPTY;
      else if (good)
         fill_d = (fill_q == EMPTY) ? ONE :
                  (fill_q == ONE)   ? TWO : FULL;
   end

   // Fill FSM: outputs.
   always_comb begin
      full = (fill_q == FULL);
   end

   // Median of three by compare/select only, so no carry or overflow concerns.
   always_comb begin
      med = (w0_q >= w1_q) ?
            ((w1_q >= w2_q) ? w1_q : ((w0_q >= w2_q) ? w2_q : w0_q)) :
            ((w0_q >= w2_q) ? w0_q : ((w1_q >= w2_q) ? w2_q : w1_q));
   end

   // Stage 2: publish the filtered value one cycle after the window moved.
   always_comb begin
      out_d       = pend_q ? (full ? med : w0_q) : out_q;
      out_valid_d = pend_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q     <= 1'b1;
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         run_q       <= 8'd0;
         rej_q       <= 8'd0;
         stale_q     <= 1'b0;
         pend_q      <= 1'b0;
         out_q       <= DEF_V;
         out_valid_q <= 1'b0;
      end else begin
         ready_q     <= ready_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         run_q       <= run_d;
         rej_q       <= rej_d;
         stale_q     <= stale_d;
         pend_q      <= pend_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign distance_out = out_q;
   assign out_valid    = out_valid_q;
   assign stale        = stale_q;
   assign reject_count = rej_q;
endmodule

// File: tb/tb_distance_filter.sv
// tb_distance_filter: directed and random samples checked against a list-based
// reference of the filter (last three valid samples, sorted median).
module tb_distance_filter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] distance_in = '0;
   logic        meas_ready = 1'b1;
   logic [15:0] distance_out;
   logic        out_valid;
   logic        stale;
   logic [7:0]  reject_count;

   int vectors = 0;
   int miscompares = 0;

   int win[$];
   int m_fill, m_run, m_rej, m_out;
   bit m_stale, m_valid;

   distance_filter dut (
      .clk(clk), .reset(reset), .distance_in(distance_in), .meas_ready(meas_ready),
      .distance_out(distance_out), .out_valid(out_valid), .stale(stale),
      .reject_count(reject_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      win.delete();
      m_fill = 0; m_run = 0; m_rej = 0; m_out = 25; m_stale = 0;
   endfunction

   function automatic int median3();
      int a[3];
      int t;
      for (int i = 0; i < 3; i++) a[i] = win[i];
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2 - i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      return a[1];
   endfunction

   function automatic void model_sample(input int d);
      m_valid = (d >= 2) && (d <= 400);
      if (m_valid) begin
         win.push_front(d);
         if (win.size() > 3) void'(win.pop_back());
         m_fill = (m_fill < 3) ? m_fill + 1 : 3;
         m_run = 0;
         m_stale = 0;
         m_out = (m_fill == 3) ? median3() : d;
      end else begin
         m_rej = (m_rej < 255) ? m_rej + 1 : 255;
         m_run = (m_run < 8) ? m_run + 1 : 8;
         if (m_run == 8) begin m_stale = 1; m_fill = 0; end
      end
   endfunction

   // One rising edge carrying d, level held for `hold` cycles with distance_in wandering.
   task automatic pulse(input int d, input int hold);
      int prev_out;
      prev_out = m_out;
      @(negedge clk);
      meas_ready = 1'b1;
      distance_in = 16'(d);
      model_sample(d);
      for (int i = 1; i <= hold + 2; i++) begin
         @(negedge clk);
         check("out_valid", int'(out_valid), (i == 2 && m_valid) ? 1 : 0);
         check("distance_out", int'(distance_out), (i >= 2) ? m_out : prev_out);
         if (i == 2) begin
            check("stale", int'(stale), int'(m_stale));
            check("reject_count", int'(reject_count), m_rej);
         end
         if (i < hold) distance_in = 16'($urandom_range(0, 500));
         else meas_ready = 1'b0;
      end
   endtask

   task automatic quiet_checks(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_valid"}, int'(out_valid), 0);
         check({tag, "_out"}, int'(distance_out), m_out);
         check({tag, "_stale"}, int'(stale), int'(m_stale));
         check({tag, "_rej"}, int'(reject_count), m_rej);
      end
   endtask

   initial begin
      int d;
      model_reset();
      // T1: meas_ready high through and after reset must not count as a sample
      repeat (3) @(negedge clk);
      reset = 1'b0;
      distance_in = 16'd300;
      quiet_checks("t1", 4);
      meas_ready = 1'b0;
      quiet_checks("t1_low", 2);
      // T2: filling window then median
      pulse(100, 1); pulse(200, 1); pulse(150, 1);
      // T3: tight window, spike, then two out-of-range values
      pulse(100, 1); pulse(102, 1); pulse(101, 1); pulse(390, 1);
      check("t3_out", int'(distance_out), 102);
      pulse(0, 1); pulse(500, 1);
      check("t3_hold", int'(distance_out), 102);
      // T4: stale after eight bad samples, then pass-through recovery
      for (int i = 0; i < 8; i++) pulse(0, 1);
      check("t4_stale", int'(stale), 1);
      pulse(50, 1);
      check("t4_out50", int'(distance_out), 50);
      check("t4_unstale", int'(stale), 0);
      pulse(60, 1);
      check("t4_out60", int'(distance_out), 60);
      // T5: long level with changing input gives exactly one sample
      pulse(77, 20);
      // Boundary values
      pulse(1, 1); pulse(2, 1); pulse(400, 1); pulse(401, 1); pulse(2, 2);
      // Random mix, with bursts of zeros to exercise the stale path
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 15) == 0)
            for (int j = 0; j < 9; j++) pulse(0, 1);
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(395, 410) : $urandom_range(0, 450);
         pulse(d, $urandom_range(1, 3));
      end
      // T6: reset one cycle after a valid edge discards the sample
      @(negedge clk);
      meas_ready = 1'b1;
      distance_in = 16'd123;
      @(negedge clk);
      meas_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      quiet_checks("t6", 3);
      // Saturation of reject_count
      for (int i = 0; i < 260; i++) pulse(i % 2 == 0 ? 0 : 1000, 1);
      check("t6_sat", int'(reject_count), 255);
      pulse(30, 1);
      check("t6_sat_hold", int'(reject_count), 255);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
